reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-stage scoreboard for the 32x32 register file in the 5-stage pipeline.
- Tracks in-flight writes per destination register and blocks issue of an instruction whose source register is still pending (RAW hazard).
- Retires entries on writeback or kill.
- Sits between the decode stage and the register file read port; drives the decode-stage stall.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; maximum per register is 2^CNT_W-1.
- MAX_INFLIGHT, 4, maximum total in-flight writes across all registers.
- WB_BYPASS, 1, when 1 a register retiring via wb this cycle counts as not busy for the hazard check (the register file writes on negedge CLK, so decode reads the new value).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  synchronous active-low reset.
- issue_valid  in  1  decode has an instruction to issue.
- issue_rs_rt  in  10  {rs[9:5], rt[4:0]}; same packing as the register file read port.
- issue_uses_rs  in  1  the instruction reads rs.
- issue_uses_rt  in  1  the instruction reads rt.
- issue_rwd  in  5  destination register; 0 means no write.
- issue_ready  out  1  issue accepted this cycle if issue_valid.
- stall  out  1  issue_valid && !issue_ready.
- wb_valid  in  1  writeback retires one write.
- wb_rwd  in  5  register being written back.
- kill_valid  in  1  squashed instruction retires without writing.
- kill_rwd  in  5  destination of the squashed instruction.
- busy_mask  out  32  registered; bit r = counter[r] != 0; bit 0 always 0.
- inflight  out  $clog2(MAX_INFLIGHT+1)  registered total pending writes.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: when RST_N=0 at posedge, all counters, busy_mask, inflight and err are cleared to 0. issue_ready is forced 0 while RST_N=0. Reset mid-operation discards every pending entry with no partial retire.
- Fire condition: fire = issue_valid && issue_ready.
- Effective busy: eff_busy[r] = busy_mask[r] && !(WB_BYPASS && wb_valid && wb_rwd==r && counter[r]==1).
- Hazard: hazard = (issue_uses_rs && rs!=0 && eff_busy[rs]) || (issue_uses_rt && rt!=0 && eff_busy[rt]).
- Ready: issue_ready = RST_N && !hazard && !(issue_rwd!=0 && counter[issue_rwd]==max) && (inflight - dec_total < MAX_INFLIGHT).
  - dec_total counts valid wb/kill events that retire this cycle.
  - A full scoreboard accepts an issue in the same cycle a retire frees a slot.
- Combinational path: issue_ready is combinational from inputs and registered state, zero latency. busy_mask and inflight update one cycle after the event.
- Per-register update: counter[r] next = counter[r] + inc - dec_wb - dec_kill.
  - inc = fire && issue_rwd==r && r!=0.
  - dec_wb = wb_valid && wb_rwd==r && counter[r]!=0.
  - dec_kill is defined the same way from kill_valid/kill_rwd.
- Simultaneous events:
  - Issue and retire to the same register in one cycle: counter unchanged.
  - wb and kill to the same register with counter>=2: decrement by 2.
  - wb and kill to the same register with counter==1: decrement by 1 and set err.
- Error cases (set err, counters never underflow):
  - wb_valid or kill_valid to a register whose counter is 0.
  - wb_rwd==0 or kill_rwd==0 with the valid asserted.
- Register 0: never tracked, never busy, never causes a hazard.
- Totals: inflight next = inflight + fire_with_dest - accepted_decrements. It always equals the sum of the counters.
- err clears only on reset.

Decomposition:
- Shared package/def file holds:
  - REG_IDX_W=5, NUM_REGS=32, REG_ZERO=5'd0.
  - rs/rt field slice positions (RS_HI=9, RS_LO=5, RT_HI=4, RT_LO=0), shared with the register file.
- One sub-module: sb_counter, a per-register CNT_W up/down counter with inputs inc/dec_a/dec_a_ok/dec_b, outputs cnt/nonzero/at_max/underflow. Instantiated for registers 1..31.
- Top level holds the hazard logic, the inflight accumulator and err.

Test Plan:
- Basic RAW: issue rwd=5 (fires) → next cycle busy_mask=0x20. Then issue rs=5 uses_rs=1 → issue_ready=0, stall=1. wb_rwd=5 in that same cycle → issue_ready=1 (WB_BYPASS), busy_mask=0 the cycle after.
- Capacity: issue rwd=1,2,3,4 back-to-back → inflight=4, then issue rwd=6 → ready=0. Same cycle wb_rwd=1 → ready=1, inflight stays 4.
- Counter saturation: 3 issues to rwd=7 (CNT_W=2, counter=3) → a 4th to rwd=7 stalls. Kill_rwd=7 → the 4th issue fires, counter stays 3.
- Simultaneous events: counter[9]=2, wb_rwd=9 and kill_rwd=9 in one cycle → counter=0, err=0. Repeat with counter[9]=1 → counter=0, err=1.
- Register 0 and errors: issue rwd=0, rs=0 → fires, busy_mask unchanged. wb_valid with wb_rwd=12 while counter[12]=0 → err=1, counters unchanged.
- Reset mid-operation: inflight=3, RST_N=0 for one cycle → issue_ready=0 that cycle. Next cycle busy_mask=0, inflight=0, err=0, and an issue with rs equal to a previously busy register fires.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the issue-stage register scoreboard and the
// register file read port that uses the same rs/rt packing.
package reg_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // Field positions inside the packed {rs, rt} read-port word.
    localparam int RS_HI = 9;
    localparam int RS_LO = 5;
    localparam int RT_HI = 4;
    localparam int RT_LO = 0;

    function automatic logic [REG_IDX_W-1:0] get_rs(input logic [2*REG_IDX_W-1:0] rs_rt);
        return rs_rt[RS_HI:RS_LO];
    endfunction

    function automatic logic [REG_IDX_W-1:0] get_rt(input logic [2*REG_IDX_W-1:0] rs_rt);
        return rs_rt[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/kill signals seen by the scoreboard.
// Issue handshake: an instruction is issued (fires) in the cycle where
// issue_valid && issue_ready at posedge CLK; issue_ready never depends on
// issue_valid, and decode holds the instruction stable while stalled.
interface reg_scoreboard_if #(
    parameter int MAX_INFLIGHT = 4
);
    import reg_scoreboard_pkg::*;

    localparam int INFL_W = $clog2(MAX_INFLIGHT + 1);

    logic                     issue_valid;
    logic [2*REG_IDX_W-1:0]   issue_rs_rt;
    logic                     issue_uses_rs;
    logic                     issue_uses_rt;
    logic [REG_IDX_W-1:0]     issue_rwd;
    logic                     issue_ready;
    logic                     stall;
    logic                     wb_valid;
    logic [REG_IDX_W-1:0]     wb_rwd;
    logic                     kill_valid;
    logic [REG_IDX_W-1:0]     kill_rwd;
    logic [NUM_REGS-1:0]      busy_mask;
    logic [INFL_W-1:0]        inflight;
    logic                     err;

    modport master (
        output issue_valid, issue_rs_rt, issue_uses_rs, issue_uses_rt, issue_rwd,
        output wb_valid, wb_rwd, kill_valid, kill_rwd,
        input  issue_ready, stall, busy_mask, inflight, err
    );

    modport slave (
        input  issue_valid, issue_rs_rt, issue_uses_rs, issue_uses_rt, issue_rwd,
        input  wb_valid, wb_rwd, kill_valid, kill_rwd,
        output issue_ready, stall, busy_mask, inflight, err
    );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// Per-register pending-write counter. dec_a is the writeback strobe and
// dec_a_ok its address match for this register; dec_b is the kill hit.
// Decrements never take the count below zero; a rejected one is reported
// on underflow.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_a_ok,
    input  logic             dec_b,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             at_max,
    output logic             underflow
);

    logic a_req;
    logic a_take;
    logic b_take;

    assign nonzero = (cnt != '0);
    assign at_max  = (cnt == {CNT_W{1'b1}});

    // Decide which retires are accepted; kill only takes what writeback left.
    always_comb begin
        a_req     = dec_a && dec_a_ok;
        a_take    = a_req && nonzero;
        b_take    = dec_b && (cnt > CNT_W'(a_take));
        underflow = (a_req && !a_take) || (dec_b && !b_take);
    end

    // Count update: issue adds one, each accepted retire removes one.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(inc && !at_max) - CNT_W'(a_take) - CNT_W'(b_take);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage scoreboard: blocks RAW hazards against in-flight writes,
// bounds total in-flight writes and flags retire protocol errors.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int WB_BYPASS    = 1
) (
    input logic              CLK,
    input logic              RST_N,
    reg_scoreboard_if.slave  sb
);

    localparam int INFL_W = $clog2(MAX_INFLIGHT + 1);

    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
    logic [CNT_W-1:0]     cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  nonzero;
    logic [NUM_REGS-1:0]  at_max;
    logic [NUM_REGS-1:0]  underflow;
    logic [NUM_REGS-1:0]  eff_busy;
    logic                 hazard;
    logic                 wb_take;
    logic                 kill_take;
    logic [INFL_W-1:0]    dec_total;
    logic                 room;
    logic                 ready;
    logic                 fire;
    logic [INFL_W-1:0]    inflight_q;
    logic                 err_q;

    assign rs = get_rs(sb.issue_rs_rt);
    assign rt = get_rt(sb.issue_rs_rt);

    // Register 0 is never tracked.
    assign cnt[0]       = '0;
    assign nonzero[0]   = 1'b0;
    assign at_max[0]    = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .inc       (fire && (sb.issue_rwd == REG_IDX_W'(r))),
            .dec_a     (sb.wb_valid),
            .dec_a_ok  (sb.wb_rwd == REG_IDX_W'(r)),
            .dec_b     (sb.kill_valid && (sb.kill_rwd == REG_IDX_W'(r))),
            .cnt       (cnt[r]),
            .nonzero   (nonzero[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    // Hazard check, accepted retires and issue acceptance.
    always_comb begin
        eff_busy = nonzero;
        // Last pending write retiring now is visible to decode through the
        // negedge register file write.
        if ((WB_BYPASS != 0) && sb.wb_valid && (cnt[sb.wb_rwd] == CNT_W'(1))) begin
            eff_busy[sb.wb_rwd] = 1'b0;
        end
        hazard = (sb.issue_uses_rs && (rs != REG_ZERO) && eff_busy[rs]) ||
                 (sb.issue_uses_rt && (rt != REG_ZERO) && eff_busy[rt]);
        wb_take   = sb.wb_valid && (sb.wb_rwd != REG_ZERO) && (cnt[sb.wb_rwd] != '0);
        kill_take = sb.kill_valid && (sb.kill_rwd != REG_ZERO) &&
                    (cnt[sb.kill_rwd] > CNT_W'(wb_take && (sb.wb_rwd == sb.kill_rwd)));
        dec_total = INFL_W'(wb_take) + INFL_W'(kill_take);
        room      = (inflight_q - dec_total) < INFL_W'(MAX_INFLIGHT);
        ready     = RST_N && !hazard && room &&
                    !((sb.issue_rwd != REG_ZERO) && at_max[sb.issue_rwd]);
    end

    assign fire           = sb.issue_valid && ready;
    assign sb.issue_ready = ready;
    assign sb.stall       = sb.issue_valid && !ready;
    assign sb.busy_mask   = nonzero;
    assign sb.inflight    = inflight_q;
    assign sb.err         = err_q;

    // Total in-flight accumulator and sticky protocol-error flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_q + INFL_W'(fire && (sb.issue_rwd != REG_ZERO)) - dec_total;
            err_q      <= err_q || (|underflow) ||
                          (sb.wb_valid && (sb.wb_rwd == REG_ZERO)) ||
                          (sb.kill_valid && (sb.kill_rwd == REG_ZERO));
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    reg_scoreboard_if #(.MAX_INFLIGHT(4)) sb_if ();

    reg_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4), .WB_BYPASS(1)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .sb    (sb_if)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        sb_if.issue_valid   = 1'b0;
        sb_if.issue_rs_rt   = '0;
        sb_if.issue_uses_rs = 1'b0;
        sb_if.issue_uses_rt = 1'b0;
        sb_if.issue_rwd     = '0;
        sb_if.wb_valid      = 1'b0;
        sb_if.wb_rwd        = '0;
        sb_if.kill_valid    = 1'b0;
        sb_if.kill_rwd      = '0;
    endtask

    task automatic drive_issue(input logic [4:0] rwd, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt);
        sb_if.issue_valid   = 1'b1;
        sb_if.issue_rwd     = rwd;
        sb_if.issue_rs_rt   = {rs, rt};
        sb_if.issue_uses_rs = urs;
        sb_if.issue_uses_rt = urt;
    endtask

    task automatic drive_wb(input logic [4:0] r);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rwd   = r;
    endtask

    task automatic drive_kill(input logic [4:0] r);
        sb_if.kill_valid = 1'b1;
        sb_if.kill_rwd   = r;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_in();
        drive_issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0);

        // reset state
        tick();
        check("rst_ready", 32'(sb_if.issue_ready), 32'd0);
        check("rst_stall", 32'(sb_if.stall), 32'd1);
        tick();
        rst_n = 1'b1;
        clear_in();
        #1;
        check("rst_busy", sb_if.busy_mask, 32'h0);
        check("rst_inflight", 32'(sb_if.inflight), 32'd0);
        check("rst_err", 32'(sb_if.err), 32'd0);

        // basic RAW with writeback bypass
        drive_issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check("raw_issue5_ready", 32'(sb_if.issue_ready), 32'd1);
        tick();
        clear_in();
        #1;
        check("raw_busy5", sb_if.busy_mask, 32'h20);
        check("raw_inflight1", 32'(sb_if.inflight), 32'd1);
        drive_issue(5'd0, 5'd5, 5'd0, 1'b1, 1'b0);
        #1;
        check("raw_hazard_ready", 32'(sb_if.issue_ready), 32'd0);
        check("raw_hazard_stall", 32'(sb_if.stall), 32'd1);
        drive_wb(5'd5);
        #1;
        check("raw_bypass_ready", 32'(sb_if.issue_ready), 32'd1);
        check("raw_bypass_stall", 32'(sb_if.stall), 32'd0);
        tick();
        clear_in();
        #1;
        check("raw_busy_clear", sb_if.busy_mask, 32'h0);
        check("raw_inflight0", 32'(sb_if.inflight), 32'd0);
        check("raw_err", 32'(sb_if.err), 32'd0);

        // capacity limit with same-cycle retire
        for (int i = 1; i <= 4; i++) begin
            drive_issue(5'(i), 5'd0, 5'd0, 1'b0, 1'b0);
            #1 check("cap_fill_ready", 32'(sb_if.issue_ready), 32'd1);
            tick();
        end
        clear_in();
        #1;
        check("cap_inflight4", 32'(sb_if.inflight), 32'd4);
        check("cap_busy", sb_if.busy_mask, 32'h1E);
        drive_issue(5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check("cap_full_ready", 32'(sb_if.issue_ready), 32'd0);
        drive_wb(5'd1);
        #1 check("cap_free_ready", 32'(sb_if.issue_ready), 32'd1);
        tick();
        clear_in();
        #1;
        check("cap_inflight_stays4", 32'(sb_if.inflight), 32'd4);
        check("cap_busy_after", sb_if.busy_mask, 32'h5C);
        begin
            logic [4:0] rl [4];
            rl = '{5'd2, 5'd3, 5'd4, 5'd6};
            for (int i = 0; i < 4; i++) begin
                drive_wb(rl[i]);
                tick();
                clear_in();
            end
        end
        #1 check("cap_drained", 32'(sb_if.inflight), 32'd0);

        // counter saturation
        for (int i = 0; i < 3; i++) begin
            drive_issue(5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
            #1 check("sat_fill_ready", 32'(sb_if.issue_ready), 32'd1);
            tick();
        end
        clear_in();
        #1;
        check("sat_inflight3", 32'(sb_if.inflight), 32'd3);
        drive_issue(5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check("sat_max_ready", 32'(sb_if.issue_ready), 32'd0);
        drive_kill(5'd7);
        #1 check("sat_kill_same_cycle_ready", 32'(sb_if.issue_ready), 32'd0);
        tick();
        sb_if.kill_valid = 1'b0;
        #1;
        check("sat_after_kill_inflight", 32'(sb_if.inflight), 32'd2);
        check("sat_after_kill_ready", 32'(sb_if.issue_ready), 32'd1);
        tick();
        clear_in();
        #1;
        check("sat_refill_inflight", 32'(sb_if.inflight), 32'd3);
        check("sat_busy7", sb_if.busy_mask, 32'h80);
        drive_kill(5'd7);
        tick();
        drive_kill(5'd7);
        tick();
        clear_in();
        #1 check("sat_busy_still7", sb_if.busy_mask, 32'h80);
        drive_kill(5'd7);
        tick();
        clear_in();
        #1;
        check("sat_drained_busy", sb_if.busy_mask, 32'h0);
        check("sat_drained_inflight", 32'(sb_if.inflight), 32'd0);
        check("sat_err", 32'(sb_if.err), 32'd0);

        // simultaneous wb and kill on one register
        drive_issue(5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        clear_in();
        #1 check("sim_inflight2", 32'(sb_if.inflight), 32'd2);
        drive_wb(5'd9);
        drive_kill(5'd9);
        tick();
        clear_in();
        #1;
        check("sim2_inflight", 32'(sb_if.inflight), 32'd0);
        check("sim2_busy", sb_if.busy_mask, 32'h0);
        check("sim2_err", 32'(sb_if.err), 32'd0);
        drive_issue(5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        clear_in();
        drive_wb(5'd9);
        drive_kill(5'd9);
        tick();
        clear_in();
        #1;
        check("sim1_inflight", 32'(sb_if.inflight), 32'd0);
        check("sim1_busy", sb_if.busy_mask, 32'h0);
        check("sim1_err", 32'(sb_if.err), 32'd1);

        // reset mid-operation
        for (int i = 1; i <= 3; i++) begin
            drive_issue(5'(i), 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        clear_in();
        #1;
        check("mid_inflight3", 32'(sb_if.inflight), 32'd3);
        check("mid_busy", sb_if.busy_mask, 32'hE);
        rst_n = 1'b0;
        drive_issue(5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check("mid_rst_ready", 32'(sb_if.issue_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_in();
        #1;
        check("mid_busy_cleared", sb_if.busy_mask, 32'h0);
        check("mid_inflight_cleared", 32'(sb_if.inflight), 32'd0);
        check("mid_err_cleared", 32'(sb_if.err), 32'd0);
        drive_issue(5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        #1 check("mid_old_src_ready", 32'(sb_if.issue_ready), 32'd1);
        tick();
        clear_in();

        // register 0 and error cases
        drive_issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1 check("r0_ready", 32'(sb_if.issue_ready), 32'd1);
        tick();
        clear_in();
        #1;
        check("r0_busy", sb_if.busy_mask, 32'h0);
        check("r0_inflight", 32'(sb_if.inflight), 32'd0);
        check("r0_err", 32'(sb_if.err), 32'd0);
        drive_issue(5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        clear_in();
        drive_wb(5'd12);
        tick();
        clear_in();
        #1;
        check("wb_empty_err", 32'(sb_if.err), 32'd1);
        check("wb_empty_inflight", 32'(sb_if.inflight), 32'd1);
        check("wb_empty_busy", sb_if.busy_mask, 32'h400);

        // bypass applies only to the last pending write
        drive_issue(5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        clear_in();
        drive_issue(5'd0, 5'd10, 5'd0, 1'b1, 1'b0);
        drive_wb(5'd10);
        #1 check("bypass_cnt2_ready", 32'(sb_if.issue_ready), 32'd0);
        tick();
        sb_if.wb_valid = 1'b0;
        #1;
        check("bypass_cnt1_inflight", 32'(sb_if.inflight), 32'd1);
        check("bypass_cnt1_hazard", 32'(sb_if.issue_ready), 32'd0);
        drive_wb(5'd10);
        #1 check("bypass_cnt1_ready", 32'(sb_if.issue_ready), 32'd1);
        tick();
        clear_in();
        #1 check("bypass_final_busy", sb_if.busy_mask, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
